alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised two-stage integer execute unit for the out-of-order core. It accepts one issued instruction per cycle from the ALU reservation station and computes every RV32I integer, branch and jump result. It resolves the next PC and flags mispredictions against the front end's prediction. The tagged result is delivered to the common data bus arbiter through a valid/ready handshake, and the unit supports backpressure, global stall (`rdy_in`) and pipeline flush.

## Interface
- `XLEN`, 32: operand, result and PC width.
- `TAG_W`, 4: ROB tag width.
- `OP_W`, 5: opcode width (encodings below).

- `clk_in`  in  1: clock; all state updates on the rising edge.
- `rst_in`  in  1: asynchronous, active-low reset.
- `rdy_in`  in  1: global enable; low freezes all state.
- `flush_in`  in  1: synchronous pipeline flush (mispredict recovery).
- `in_valid`  in  1: issue request.
- `in_ready`  out  1: unit accepts this cycle.
- `in_op`  in  `OP_W`: operation.
- `in_use_imm`  in  1: operand B = `in_imm` instead of `in_rs2` (ops 0-9 only).
- `in_rs1`, `in_rs2`, `in_imm`  in  `XLEN`: operands; `in_imm` is already sign-extended.
- `in_pc`  in  `XLEN`: instruction PC.
- `in_pred_pc`  in  `XLEN`: next PC predicted by the front end.
- `in_tag`  in  `TAG_W`: ROB tag.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: CDB accepts.
- `out_tag`  out  `TAG_W`: tag of the result.
- `out_result`  out  `XLEN`: rd value.
- `out_next_pc`  out  `XLEN`: resolved next PC.
- `out_taken`  out  1: control transfer taken.
- `out_mispredict`  out  1: `out_next_pc` != predicted PC. Asserted only for ops 10-17.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU, 16 JAL, 17 JALR, 18 LUI, 19 AUIPC.
- Undefined opcodes: result 0, next_pc = pc+4, taken 0, mispredict 0.
- Ops 0-9:
  - B = `in_use_imm` ? imm : rs2.
  - Arithmetic is modulo 2^XLEN.
  - Shift amount = B[$clog2(XLEN)-1:0].
  - SLT/BLT/BGE compare signed; SLTU/BLTU/BGEU compare unsigned.
  - next_pc = pc+4, taken 0.
- Branches (10-15): result 0; taken = condition; next_pc = taken ? pc+imm : pc+4.
- JAL: result pc+4, taken 1, next_pc pc+imm.
- JALR: result pc+4, taken 1, next_pc (rs1+imm) with bit 0 cleared.
- LUI: result imm. AUIPC: result pc+imm. Both: next_pc pc+4, taken 0.
- mispredict = (op in 10-17) && (next_pc != pred_pc).
- Pipeline:
  - S1 register holds the accepted instruction.
  - Results are computed combinationally from S1 and captured into the S2 (output) register.
  - Output ports are driven directly by S2.
- S1 advances into S2 when S2 is empty or `out_ready` is high.
- in_ready = rdy_in && !flush_in && (!s1_valid || !s2_valid || out_ready). It is combinational.
- Handshake: a transfer occurs on an edge where valid && ready. Payload is held stable while out_valid && !out_ready.

## Timing
- Reset (`rst_in` low, asynchronous): both valids 0; all output payload registers 0; out_valid 0. `in_ready` reads 1 once `rst_in` rises with `rdy_in` high.
- Latency: instruction accepted at edge k shows out_valid=1 after edge k+1 (two register stages). Throughput is 1 per cycle with `out_ready` held high.
- Backpressure: S2 holds while `out_ready` is low. S1 fills, then `in_ready` drops. No instruction is lost or duplicated. S2 drains on the first edge with `out_ready` high, and S1 moves in on the same edge.
- `rdy_in` low: no capture, no advance, no output transfer. Outputs hold their values. `out_valid` may remain high, but `out_ready` is ignored.
- `flush_in` high at an edge, regardless of `rdy_in`: both valids clear, no new accept, out_valid=0 after that edge. A result presented in the flush cycle is not considered transferred.
- Flush and reset mid-backpressure discard all held instructions.

## Test plan
- ADD, rs1=5, rs2=7, tag 3, out_ready=1, accepted edge 0 -> out_valid after edge 1, result 12, tag 3, next_pc=pc+4, mispredict 0.
- SRA rs1=0x80000000, imm=4, use_imm=1 -> 0xF8000000. SRL same operands -> 0x08000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT same operands -> 0.
- BNE rs1=1, rs2=2, pc=0x100, imm=0x20, pred_pc=0x104 -> taken 1, next_pc 0x120, mispredict 1. BEQ same operands, pred 0x104 -> mispredict 0.
- JALR rs1=0x1001, imm=2, pc=0x40 -> next_pc 0x1002, result 0x44.
- Back-to-back stream of 4 ops with out_ready low for 3 cycles after the first result -> in_ready drops after 2 accepted. All 4 results are delivered in order with correct tags, and the first is held stable during the stall.
- Two ops in flight, flush_in pulsed 1 cycle -> out_valid 0 next cycle, neither tag emitted. rdy_in low for 2 cycles mid-stream -> no state change, and the stream resumes intact.

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage RV32I integer/branch/jump execute unit
// S1 holds the issued instruction; results are computed from S1 into the S2 output register.
module alu_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_use_imm,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_pred_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_result,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_taken,
    output logic             out_mispredict
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(16);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(18);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(19);

    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_op_q, s1_op_d;
    logic             s1_use_imm_q, s1_use_imm_d;
    logic [XLEN-1:0]  s1_rs1_q, s1_rs1_d;
    logic [XLEN-1:0]  s1_rs2_q, s1_rs2_d;
    logic [XLEN-1:0]  s1_imm_q, s1_imm_d;
    logic [XLEN-1:0]  s1_pc_q, s1_pc_d;
    logic [XLEN-1:0]  s1_pred_pc_q, s1_pred_pc_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [XLEN-1:0]  out_next_pc_q, out_next_pc_d;
    logic             out_taken_q, out_taken_d;
    logic             out_mispredict_q, out_mispredict_d;

    logic [XLEN-1:0] op_b, pc_plus4, br_target, jalr_target;
    logic [SH_W-1:0] shamt;
    logic            is_ctrl, br_eq, br_lt, br_ltu, slt_s, slt_u;
    logic [XLEN-1:0] ex_result, ex_next_pc;
    logic            ex_taken, ex_mispredict;
    logic            s1_adv, s2_fire, accept;

    always_comb begin
        op_b        = s1_use_imm_q ? s1_imm_q : s1_rs2_q;
        shamt       = op_b[SH_W-1:0];
        pc_plus4    = s1_pc_q + XLEN'(4);
        br_target   = s1_pc_q + s1_imm_q;
        jalr_target = s1_rs1_q + s1_imm_q;
        br_eq       = (s1_rs1_q == s1_rs2_q);
        br_lt       = ($signed(s1_rs1_q) < $signed(s1_rs2_q));
        br_ltu      = (s1_rs1_q < s1_rs2_q);
        slt_s       = ($signed(s1_rs1_q) < $signed(op_b));
        slt_u       = (s1_rs1_q < op_b);

        ex_result  = '0;
        ex_next_pc = pc_plus4;
        ex_taken   = 1'b0;
        is_ctrl    = 1'b0;
        case (s1_op_q)
            OP_ADD:   ex_result = s1_rs1_q + op_b;
            OP_SUB:   ex_result = s1_rs1_q - op_b;
            OP_SLL:   ex_result = s1_rs1_q << shamt;
            OP_SLT:   ex_result = {{(XLEN-1){1'b0}}, slt_s};
            OP_SLTU:  ex_result = {{(XLEN-1){1'b0}}, slt_u};
            OP_XOR:   ex_result = s1_rs1_q ^ op_b;
            OP_SRL:   ex_result = s1_rs1_q >> shamt;
            OP_SRA:   ex_result = XLEN'($signed(s1_rs1_q) >>> shamt);
            OP_OR:    ex_result = s1_rs1_q | op_b;
            OP_AND:   ex_result = s1_rs1_q & op_b;
            OP_BEQ:   begin is_ctrl = 1'b1; ex_taken = br_eq;   end
            OP_BNE:   begin is_ctrl = 1'b1; ex_taken = !br_eq;  end
            OP_BLT:   begin is_ctrl = 1'b1; ex_taken = br_lt;   end
            OP_BGE:   begin is_ctrl = 1'b1; ex_taken = !br_lt;  end
            OP_BLTU:  begin is_ctrl = 1'b1; ex_taken = br_ltu;  end
            OP_BGEU:  begin is_ctrl = 1'b1; ex_taken = !br_ltu; end
            OP_JAL: begin
                is_ctrl    = 1'b1;
                ex_taken   = 1'b1;
                ex_result  = pc_plus4;
                ex_next_pc = br_target;
            end
            OP_JALR: begin
                is_ctrl    = 1'b1;
                ex_taken   = 1'b1;
                ex_result  = pc_plus4;
                ex_next_pc = {jalr_target[XLEN-1:1], 1'b0};
            end
            OP_LUI:   ex_result = s1_imm_q;
            OP_AUIPC: ex_result = br_target;
            default:  ex_result = '0;
        endcase
        // Conditional branches redirect only when taken; JAL/JALR set their target above.
        if (is_ctrl && ex_taken && (s1_op_q != OP_JAL) && (s1_op_q != OP_JALR)) begin
            ex_next_pc = br_target;
        end
        ex_mispredict = is_ctrl && (ex_next_pc != s1_pred_pc_q);
    end

    assign in_ready = rdy_in && !flush_in && (!s1_valid_q || !out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign s2_fire  = out_valid_q && out_ready;

    always_comb begin
        s1_valid_d       = s1_valid_q;
        s1_op_d          = s1_op_q;
        s1_use_imm_d     = s1_use_imm_q;
        s1_rs1_d         = s1_rs1_q;
        s1_rs2_d         = s1_rs2_q;
        s1_imm_d         = s1_imm_q;
        s1_pc_d          = s1_pc_q;
        s1_pred_pc_d     = s1_pred_pc_q;
        s1_tag_d         = s1_tag_q;
        out_valid_d      = out_valid_q;
        out_tag_d        = out_tag_q;
        out_result_d     = out_result_q;
        out_next_pc_d    = out_next_pc_q;
        out_taken_d      = out_taken_q;
        out_mispredict_d = out_mispredict_q;

        if (flush_in) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else if (rdy_in) begin
            if (s1_adv) begin
                out_valid_d      = 1'b1;
                out_tag_d        = s1_tag_q;
                out_result_d     = ex_result;
                out_next_pc_d    = ex_next_pc;
                out_taken_d      = ex_taken;
                out_mispredict_d = ex_mispredict;
            end else if (s2_fire) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                s1_valid_d   = 1'b1;
                s1_op_d      = in_op;
                s1_use_imm_d = in_use_imm;
                s1_rs1_d     = in_rs1;
                s1_rs2_d     = in_rs2;
                s1_imm_d     = in_imm;
                s1_pc_d      = in_pc;
                s1_pred_pc_d = in_pred_pc;
                s1_tag_d     = in_tag;
            end else if (s1_adv) begin
                s1_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid_q       <= 1'b0;
            s1_op_q          <= '0;
            s1_use_imm_q     <= 1'b0;
            s1_rs1_q         <= '0;
            s1_rs2_q         <= '0;
            s1_imm_q         <= '0;
            s1_pc_q          <= '0;
            s1_pred_pc_q     <= '0;
            s1_tag_q         <= '0;
            out_valid_q      <= 1'b0;
            out_tag_q        <= '0;
            out_result_q     <= '0;
            out_next_pc_q    <= '0;
            out_taken_q      <= 1'b0;
            out_mispredict_q <= 1'b0;
        end else begin
            s1_valid_q       <= s1_valid_d;
            s1_op_q          <= s1_op_d;
            s1_use_imm_q     <= s1_use_imm_d;
            s1_rs1_q         <= s1_rs1_d;
            s1_rs2_q         <= s1_rs2_d;
            s1_imm_q         <= s1_imm_d;
            s1_pc_q          <= s1_pc_d;
            s1_pred_pc_q     <= s1_pred_pc_d;
            s1_tag_q         <= s1_tag_d;
            out_valid_q      <= out_valid_d;
            out_tag_q        <= out_tag_d;
            out_result_q     <= out_result_d;
            out_next_pc_q    <= out_next_pc_d;
            out_taken_q      <= out_taken_d;
            out_mispredict_q <= out_mispredict_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_tag        = out_tag_q;
    assign out_result     = out_result_q;
    assign out_next_pc    = out_next_pc_q;
    assign out_taken      = out_taken_q;
    assign out_mispredict = out_mispredict_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe with a behavioural RV32I reference model
module tb_alu_pipe;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, in_valid, in_ready, in_use_imm;
    logic [4:0]  in_op;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc, in_pred_pc;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready, out_taken, out_mispredict;
    logic [3:0]  out_tag;
    logic [31:0] out_result, out_next_pc;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] res;
        logic [31:0] npc;
        logic        tk;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    exp_t held;
    bit   held_v = 0;

    alu_pipe #(.XLEN(32), .TAG_W(4), .OP_W(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_use_imm(in_use_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .in_pred_pc(in_pred_pc), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_tag(out_tag), .out_result(out_result),
        .out_next_pc(out_next_pc), .out_taken(out_taken), .out_mispredict(out_mispredict)
    );

    always #5 clk_in = ~clk_in;

    function automatic exp_t ref_model(input logic [4:0] op, input logic ui,
                                       input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm, input logic [31:0] pc,
                                       input logic [31:0] pred, input logic [3:0] tag);
        exp_t        e;
        logic [31:0] b, ones;
        int unsigned sh;
        bit          cond;
        b    = ui ? imm : rs2;
        sh   = b % 32;
        ones = 32'hFFFF_FFFF;
        e.tag = tag;
        e.res = 0;
        e.npc = pc + 4;
        e.tk  = 0;
        cond  = 0;
        case (op)
            0:  e.res = rs1 + b;
            1:  e.res = rs1 - b;
            2:  e.res = rs1 << sh;
            3:  e.res = (int'(rs1) < int'(b)) ? 1 : 0;
            4:  e.res = (rs1 < b) ? 1 : 0;
            5:  e.res = rs1 ^ b;
            6:  e.res = rs1 >> sh;
            7:  e.res = (rs1 >> sh) | (rs1[31] ? ~(ones >> sh) : 32'h0);
            8:  e.res = rs1 | b;
            9:  e.res = rs1 & b;
            10: cond = (rs1 == rs2);
            11: cond = (rs1 != rs2);
            12: cond = (int'(rs1) < int'(rs2));
            13: cond = (int'(rs1) >= int'(rs2));
            14: cond = (rs1 < rs2);
            15: cond = (rs1 >= rs2);
            16: begin e.res = pc + 4; e.tk = 1; e.npc = pc + imm; end
            17: begin e.res = pc + 4; e.tk = 1; e.npc = (rs1 + imm) & ~32'h1; end
            18: e.res = imm;
            19: e.res = pc + imm;
            default: e.res = 0;
        endcase
        if (op >= 10 && op <= 15) begin
            e.tk = cond;
            if (cond) e.npc = pc + imm;
        end
        e.mis = (op >= 10 && op <= 17) && (e.npc != pred);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops on every output transfer, discards on flush, and checks stall stability.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (held_v) begin
                checks++;
                if (!out_valid || {out_tag, out_result, out_next_pc, out_taken, out_mispredict} !== held) begin
                    errors++;
                    $display("FAIL hold_stable actual_valid=%0b actual=%h expected=%h", out_valid,
                             {out_tag, out_result, out_next_pc, out_taken, out_mispredict}, held);
                end
            end
            if (flush_in) begin
                sb.delete();
            end else if (rdy_in && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output actual_tag=%0d expected=none", out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({out_tag, out_result, out_next_pc, out_taken, out_mispredict} !== e) begin
                        errors++;
                        $display("FAIL result actual tag=%0d res=%h npc=%h tk=%0b mis=%0b expected tag=%0d res=%h npc=%h tk=%0b mis=%0b",
                                 out_tag, out_result, out_next_pc, out_taken, out_mispredict,
                                 e.tag, e.res, e.npc, e.tk, e.mis);
                    end
                end
            end
            held_v = out_valid && !flush_in && !(rdy_in && out_ready);
            held   = {out_tag, out_result, out_next_pc, out_taken, out_mispredict};
        end else begin
            held_v = 0;
        end
    end

    task automatic step(output bit acc);
        @(negedge clk_in);
        acc = in_valid && in_ready;
        if (acc) sb.push_back(ref_model(in_op, in_use_imm, in_rs1, in_rs2, in_imm, in_pc, in_pred_pc, in_tag));
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_fields(input logic [4:0] op, input logic ui, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                              input logic [31:0] pred, input logic [3:0] tag);
        in_op = op; in_use_imm = ui; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_pc = pc; in_pred_pc = pred; in_tag = tag;
    endtask

    task automatic rand_fields();
        logic [31:0] pc, imm;
        int          p;
        pc  = $urandom & ~32'h3;
        imm = ($urandom % 2) ? $urandom : (($urandom % 64) - 32);
        p   = $urandom % 3;
        set_fields(5'($urandom_range(0, 21)), 1'($urandom), $urandom, $urandom, imm, pc,
                   (p == 0) ? pc + 4 : (p == 1) ? pc + imm : $urandom, 4'($urandom));
        if ($urandom % 4 == 0) in_rs2 = in_rs1;
    endtask

    task automatic issue(input logic [4:0] op, input logic ui, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] pred, input logic [3:0] tag);
        bit acc;
        acc = 0;
        set_fields(op, ui, rs1, rs2, imm, pc, pred, tag);
        in_valid = 1;
        for (int i = 0; i < 50 && !acc; i++) step(acc);
        in_valid = 0;
        if (!acc) begin
            errors++;
            $display("FAIL issue_timeout actual=not_accepted expected=accepted");
        end
    endtask

    task automatic directed(input string name, input logic [4:0] op, input logic ui,
                            input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [31:0] pred, input logic [3:0] tag,
                            input logic [31:0] x_res, input logic [31:0] x_npc,
                            input logic x_tk, input logic x_mis);
        issue(op, ui, rs1, rs2, imm, pc, pred, tag);
        @(negedge clk_in);
        chk({name, "_lat_early"}, 32'(out_valid), 0);
        @(posedge clk_in);
        #1;
        @(negedge clk_in);
        chk({name, "_valid"}, 32'(out_valid), 1);
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        chk({name, "_result"}, out_result, x_res);
        chk({name, "_next_pc"}, out_next_pc, x_npc);
        chk({name, "_taken"}, 32'(out_taken), 32'(x_tk));
        chk({name, "_mispredict"}, 32'(out_mispredict), 32'(x_mis));
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain(input string name);
        in_valid = 0; out_ready = 1; rdy_in = 1; flush_in = 0;
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk_in);
            #1;
        end
        chk({name, "_drained"}, 32'(sb.size()), 0);
    endtask

    initial begin
        bit acc;
        int n_acc;
        rst_in = 0; rdy_in = 1; flush_in = 0; in_valid = 0; out_ready = 1;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_result", out_result, 0);
        chk("reset_next_pc", out_next_pc, 0);
        chk("reset_tag_flags", {27'h0, out_tag, out_taken | out_mispredict}, 0);
        @(posedge clk_in);
        #1;
        rst_in = 1;
        @(negedge clk_in);
        chk("reset_in_ready", 32'(in_ready), 1);
        @(posedge clk_in);
        #1;

        directed("add", 0, 0, 5, 7, 0, 32'h0, 32'h4, 3, 12, 32'h4, 0, 0);
        directed("sra", 7, 1, 32'h8000_0000, 0, 4, 32'h10, 32'h0, 1, 32'hF800_0000, 32'h14, 0, 0);
        directed("srl", 6, 1, 32'h8000_0000, 0, 4, 32'h10, 32'h0, 2, 32'h0800_0000, 32'h14, 0, 0);
        directed("sltu", 4, 0, 1, 32'hFFFF_FFFF, 0, 32'h20, 32'h0, 4, 1, 32'h24, 0, 0);
        directed("slt", 3, 0, 1, 32'hFFFF_FFFF, 0, 32'h20, 32'h0, 5, 0, 32'h24, 0, 0);
        directed("bne", 11, 0, 1, 2, 32'h20, 32'h100, 32'h104, 6, 0, 32'h120, 1, 1);
        directed("beq", 10, 0, 1, 2, 32'h20, 32'h100, 32'h104, 7, 0, 32'h104, 0, 0);
        directed("jalr", 17, 0, 32'h1001, 0, 2, 32'h40, 32'h44, 8, 32'h44, 32'h1002, 1, 1);
        directed("undef", 21, 1, 9, 9, 32'h30, 32'h200, 32'h0, 9, 0, 32'h204, 0, 0);

        // Backpressure: S2 and S1 fill, then in_ready must drop.
        out_ready = 0;
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            set_fields(0, 1, 32'(100 * (n_acc + 1)), 0, 32'(n_acc), 32'h300, 0, 4'(10 + n_acc));
            in_valid = 1;
            step(acc);
            if (acc) n_acc++;
        end
        chk("bp_accepted_two", 32'(n_acc), 2);
        @(negedge clk_in);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        @(posedge clk_in);
        #1;
        out_ready = 1;
        for (int c = 0; c < 20 && n_acc < 4; c++) begin
            set_fields(0, 1, 32'(100 * (n_acc + 1)), 0, 32'(n_acc), 32'h300, 0, 4'(10 + n_acc));
            in_valid = 1;
            step(acc);
            if (acc) n_acc++;
        end
        chk("bp_accepted_all", 32'(n_acc), 4);
        drain("bp");

        // Flush with two instructions in flight.
        out_ready = 0;
        issue(1, 0, 50, 8, 0, 0, 0, 4'hA);
        issue(9, 0, 32'hF0, 32'h3C, 0, 0, 0, 4'hB);
        flush_in = 1;
        @(posedge clk_in);
        #1;
        flush_in = 0;
        @(negedge clk_in);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        @(posedge clk_in);
        #1;
        out_ready = 1;
        repeat (4) @(posedge clk_in);
        #1;
        drain("flush");

        // rdy_in low mid-stream freezes everything.
        issue(0, 0, 1, 2, 0, 0, 0, 1);
        issue(0, 0, 3, 4, 0, 0, 0, 2);
        in_valid = 1;
        rdy_in = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_in);
            chk("rdy_low_in_ready", 32'(in_ready), 0);
            @(posedge clk_in);
            #1;
        end
        in_valid = 0;
        rdy_in = 1;
        drain("rdy");

        // Randomised traffic with backpressure, stalls and occasional flushes.
        for (int c = 0; c < 600; c++) begin
            rand_fields();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            rdy_in    = ($urandom % 8) != 0;
            flush_in  = ($urandom % 50) == 0;
            step(acc);
        end
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
